// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

   localparam int unsigned CNT_W = 3;
   localparam int unsigned BE_W  = 4;

   localparam logic [BE_W-1:0] BE_ALL = 4'hF;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } arb_state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } arb_owner_e;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker: bit 0 is the fetch requester, bit 1 the data requester.
module arb_rr2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  arb_owner_e last_owner,
   output arb_owner_e winner,
   output logic       valid
);

   // A lone requester wins outright; a tie goes to whoever was not served last.
   always_comb begin
      winner = OWN_IF;
      valid  = |req;
      case (req)
         2'b01:   winner = OWN_IF;
         2'b10:   winner = OWN_D;
         2'b11:   winner = (last_owner == OWN_IF) ? OWN_D : OWN_IF;
         default: winner = OWN_IF;
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch and load/store paths,
// one transaction in flight at a time, with a fixed memory latency.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned MEM_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [BE_W-1:0]   d_be,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [BE_W-1:0]   mem_be,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   arb_state_e       r_state;
   arb_state_e       w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   arb_owner_e       r_owner;
   arb_owner_e       w_owner_nxt;
   arb_owner_e       r_last_owner;
   arb_owner_e       w_last_owner_nxt;
   logic             r_is_write;
   logic             w_is_write_nxt;

   arb_owner_e       w_winner;
   logic             w_valid;
   logic             w_grant;
   logic             w_done;

   arb_rr2 u_rr (
      .req        ({d_req, if_req}),
      .last_owner (r_last_owner),
      .winner     (w_winner),
      .valid      (w_valid)
   );

   // Gating with reset_n keeps every output low while reset is held.
   assign w_grant = reset_n && (r_state == S_IDLE) && w_valid;
   assign w_done  = reset_n && (r_state == S_WAIT) && (r_cnt == CNT_W'(MEM_LATENCY));

   // State register and transaction bookkeeping.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_owner      <= OWN_IF;
         r_last_owner <= OWN_IF;
         r_is_write   <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_owner      <= w_owner_nxt;
         r_last_owner <= w_last_owner_nxt;
         r_is_write   <= w_is_write_nxt;
      end
   end

   // Next state: grant in idle starts the latency count, completion returns to idle.
   always_comb begin
      w_state_nxt      = r_state;
      w_cnt_nxt        = r_cnt;
      w_owner_nxt      = r_owner;
      w_last_owner_nxt = r_last_owner;
      w_is_write_nxt   = r_is_write;
      case (r_state)
         S_IDLE: begin
            if (w_grant) begin
               w_state_nxt      = S_WAIT;
               w_cnt_nxt        = CNT_W'(1);
               w_owner_nxt      = w_winner;
               w_last_owner_nxt = w_winner;
               w_is_write_nxt   = (w_winner == OWN_D) && d_we;
            end
         end
         S_WAIT: begin
            if (w_done) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Outputs: memory strobe and grant on the grant cycle, response pulse on completion.
   always_comb begin
      if_gnt    = 1'b0;
      d_gnt     = 1'b0;
      if_rvalid = 1'b0;
      d_rvalid  = 1'b0;
      if_rdata  = '0;
      d_rdata   = '0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_be    = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (w_grant) begin
         mem_req = 1'b1;
         if (w_winner == OWN_D) begin
            d_gnt     = 1'b1;
            mem_we    = d_we;
            mem_be    = d_be;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
         end else begin
            if_gnt    = 1'b1;
            mem_be    = BE_ALL;
            mem_addr  = if_addr;
         end
      end
      if (w_done) begin
         if (r_owner == OWN_D) begin
            d_rvalid = 1'b1;
            d_rdata  = r_is_write ? '0 : mem_rdata;
         end else begin
            if_rvalid = 1'b1;
            if_rdata  = mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: one instance per latency 1..7, each with its own memory model.
module tb_mem_port_arbiter;

   localparam int unsigned NL = 7;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [NL:1] if_req, if_gnt, if_rvalid;
   logic [NL:1] d_req, d_we, d_gnt, d_rvalid;
   logic [NL:1] mem_req, mem_we;
   logic [31:0] if_addr   [1:NL];
   logic [31:0] if_rdata  [1:NL];
   logic [31:0] d_addr    [1:NL];
   logic [31:0] d_wdata   [1:NL];
   logic [31:0] d_rdata   [1:NL];
   logic [3:0]  d_be      [1:NL];
   logic [3:0]  mem_be    [1:NL];
   logic [31:0] mem_addr  [1:NL];
   logic [31:0] mem_wdata [1:NL];
   logic [31:0] mem_rdata [1:NL];

   int n_checks;
   int n_errors;

   always #5 clk = ~clk;

   // Memory contents as a pure function of address.
   function automatic logic [31:0] memf(input logic [31:0] a);
      if (a == 32'h0001_0000) return 32'h0050_0093;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
   endfunction

   genvar g;
   for (g = 1; g <= NL; g++) begin : g_lat
      logic [31:0] ma;
      logic [3:0]  age;

      mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(g)) u_dut (
         .clk       (clk),
         .reset_n   (reset_n),
         .if_req    (if_req[g]),
         .if_addr   (if_addr[g]),
         .if_gnt    (if_gnt[g]),
         .if_rvalid (if_rvalid[g]),
         .if_rdata  (if_rdata[g]),
         .d_req     (d_req[g]),
         .d_we      (d_we[g]),
         .d_be      (d_be[g]),
         .d_addr    (d_addr[g]),
         .d_wdata   (d_wdata[g]),
         .d_gnt     (d_gnt[g]),
         .d_rvalid  (d_rvalid[g]),
         .d_rdata   (d_rdata[g]),
         .mem_req   (mem_req[g]),
         .mem_we    (mem_we[g]),
         .mem_be    (mem_be[g]),
         .mem_addr  (mem_addr[g]),
         .mem_wdata (mem_wdata[g]),
         .mem_rdata (mem_rdata[g])
      );

      // Memory model: data is valid only exactly g cycles after the strobe.
      always @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            ma  <= '0;
            age <= '0;
         end else if (mem_req[g]) begin
            ma  <= mem_addr[g];
            age <= 4'd1;
         end else if (age != 4'hF) begin
            age <= age + 4'd1;
         end
      end
      assign mem_rdata[g] = (age == 4'(g)) ? memf(ma) : {28'hBAD0000, age};
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      if_req = '0;
      d_req  = '0;
      d_we   = '0;
      for (int i = 1; i <= int'(NL); i++) begin
         if_addr[i] = '0;
         d_addr[i]  = '0;
         d_wdata[i] = '0;
         d_be[i]    = '0;
      end
   endtask

   task automatic do_reset();
      clear_inputs();
      reset_n = 1'b0;
      next_cycle();
      next_cycle();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [31:0] acc;
      reset_n = 1'b0;
      if_req  = '1;
      d_req   = '1;
      for (int i = 1; i <= int'(NL); i++) begin
         if_addr[i] = 32'hFFFF_FFF0;
         d_addr[i]  = 32'hFFFF_FFF4;
         d_wdata[i] = 32'hFFFF_FFFF;
         d_be[i]    = 4'hF;
      end
      @(negedge clk);
      n_checks++;
      if ({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_req, mem_we} !== '0) begin
         n_errors++;
         $display("FAIL reset_ctrl: got %h want 0", {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_req, mem_we});
      end
      acc = '0;
      for (int i = 1; i <= int'(NL); i++)
         acc |= mem_addr[i] | mem_wdata[i] | if_rdata[i] | d_rdata[i] | {28'h0, mem_be[i]};
      n_checks++;
      if (acc !== 32'h0) begin
         n_errors++;
         $display("FAIL reset_data: got %h want 0", acc);
      end
      next_cycle();
      clear_inputs();
      reset_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({if_gnt, d_gnt, mem_req} !== '0) begin
         n_errors++;
         $display("FAIL idle_after_reset: got %h want 0", {if_gnt, d_gnt, mem_req});
      end
      next_cycle();
   endtask

   task automatic test_single_fetch();
      if_req[1]  = 1'b1;
      if_addr[1] = 32'h0001_0000;
      @(negedge clk);
      n_checks++;
      if ({if_gnt[1], d_gnt[1], mem_req[1], mem_we[1], mem_be[1], mem_addr[1]} !==
          {1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 32'h0001_0000}) begin
         n_errors++;
         $display("FAIL fetch_grant: got %h want %h",
                  {if_gnt[1], d_gnt[1], mem_req[1], mem_we[1], mem_be[1], mem_addr[1]},
                  {1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 32'h0001_0000});
      end
      next_cycle();
      if_req[1] = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({if_rvalid[1], if_rdata[1], if_gnt[1], mem_req[1]} !== {1'b1, 32'h0050_0093, 1'b0, 1'b0}) begin
         n_errors++;
         $display("FAIL fetch_rvalid: got %h want %h",
                  {if_rvalid[1], if_rdata[1], if_gnt[1], mem_req[1]}, {1'b1, 32'h0050_0093, 1'b0, 1'b0});
      end
      next_cycle();
      @(negedge clk);
      n_checks++;
      if ({if_rvalid[1], if_rdata[1]} !== 33'h0) begin
         n_errors++;
         $display("FAIL fetch_after: got %h want 0", {if_rvalid[1], if_rdata[1]});
      end
      next_cycle();
   endtask

   task automatic test_data_write();
      d_req[3]   = 1'b1;
      d_we[3]    = 1'b1;
      d_be[3]    = 4'b0011;
      d_addr[3]  = 32'h0000_0100;
      d_wdata[3] = 32'hDEAD_BEEF;
      @(negedge clk);
      n_checks++;
      if ({d_gnt[3], if_gnt[3], mem_req[3], mem_we[3], mem_be[3], mem_addr[3], mem_wdata[3]} !==
          {1'b1, 1'b0, 1'b1, 1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF}) begin
         n_errors++;
         $display("FAIL write_grant: got %h want %h",
                  {d_gnt[3], if_gnt[3], mem_req[3], mem_we[3], mem_be[3], mem_addr[3], mem_wdata[3]},
                  {1'b1, 1'b0, 1'b1, 1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF});
      end
      next_cycle();
      clear_inputs();
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         n_checks++;
         if ({d_rvalid[3], d_rdata[3], mem_req[3], mem_wdata[3]} !== {(c == 3), 32'h0, 1'b0, 32'h0}) begin
            n_errors++;
            $display("FAIL write_ack c%0d: got %h want %h", c,
                     {d_rvalid[3], d_rdata[3], mem_req[3], mem_wdata[3]}, {(c == 3), 32'h0, 1'b0, 32'h0});
         end
         next_cycle();
      end
   endtask

   task automatic test_tie();
      logic [1:0]  exp_g, exp_rv;
      logic [31:0] exp_d, exp_i;
      do_reset();
      if_req[1]  = 1'b1;
      d_req[1]   = 1'b1;
      d_we[1]    = 1'b0;
      d_be[1]    = 4'hF;
      if_addr[1] = 32'h0000_2000;
      d_addr[1]  = 32'h0000_3000;
      for (int c = 0; c < 8; c++) begin
         exp_g  = (c % 2 != 0) ? 2'b00 : ((c % 4 == 0) ? 2'b10 : 2'b01);
         exp_rv = (c % 2 == 0) ? 2'b00 : ((c % 4 == 1) ? 2'b10 : 2'b01);
         exp_d  = exp_rv[1] ? memf(32'h0000_3000) : 32'h0;
         exp_i  = exp_rv[0] ? memf(32'h0000_2000) : 32'h0;
         @(negedge clk);
         n_checks++;
         if ({d_gnt[1], if_gnt[1], d_rvalid[1], if_rvalid[1], d_rdata[1], if_rdata[1]} !==
             {exp_g, exp_rv, exp_d, exp_i}) begin
            n_errors++;
            $display("FAIL tie c%0d: got %h want %h", c,
                     {d_gnt[1], if_gnt[1], d_rvalid[1], if_rvalid[1], d_rdata[1], if_rdata[1]},
                     {exp_g, exp_rv, exp_d, exp_i});
         end
         next_cycle();
      end
      clear_inputs();
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_data;
      if_req[2]  = 1'b1;
      if_addr[2] = 32'h0000_4000;
      for (int c = 0; c < 6; c++) begin
         if (c == 1) if_addr[2] = 32'h0000_4400;
         exp_data = (c == 2) ? memf(32'h0000_4000) : ((c == 5) ? memf(32'h0000_4400) : 32'h0);
         @(negedge clk);
         n_checks++;
         if ({if_gnt[2], if_rvalid[2], if_rdata[2]} !== {(c == 0 || c == 3), (c == 2 || c == 5), exp_data}) begin
            n_errors++;
            $display("FAIL b2b c%0d: got %h want %h", c, {if_gnt[2], if_rvalid[2], if_rdata[2]},
                     {(c == 0 || c == 3), (c == 2 || c == 5), exp_data});
         end
         next_cycle();
      end
      clear_inputs();
   endtask

   task automatic test_reset_mid();
      if_req[4]  = 1'b1;
      if_addr[4] = 32'h0000_5000;
      @(negedge clk);
      n_checks++;
      if (if_gnt[4] !== 1'b1) begin
         n_errors++;
         $display("FAIL rmid_grant: got %b want 1", if_gnt[4]);
      end
      next_cycle();
      if_req[4] = 1'b0;
      next_cycle();
      for (int c = 2; c < 4; c++) begin
         reset_n = 1'b0;
         if (c == 3) begin
            d_req[4]  = 1'b1;
            d_we[4]   = 1'b0;
            d_be[4]   = 4'hF;
            d_addr[4] = 32'h0000_6000;
         end
         @(negedge clk);
         n_checks++;
         if ({if_gnt[4], if_rvalid[4], if_rdata[4], d_gnt[4], d_rvalid[4], d_rdata[4],
              mem_req[4], mem_we[4], mem_be[4], mem_addr[4], mem_wdata[4]} !== '0) begin
            n_errors++;
            $display("FAIL rmid_outputs c%0d: got %h want 0", c,
                     {if_gnt[4], if_rvalid[4], if_rdata[4], d_gnt[4], d_rvalid[4], d_rdata[4],
                      mem_req[4], mem_we[4], mem_be[4], mem_addr[4], mem_wdata[4]});
         end
         next_cycle();
      end
      reset_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({d_gnt[4], mem_addr[4]} !== {1'b1, 32'h0000_6000}) begin
         n_errors++;
         $display("FAIL rmid_release: got %h want %h", {d_gnt[4], mem_addr[4]}, {1'b1, 32'h0000_6000});
      end
      next_cycle();
      clear_inputs();
      for (int c = 5; c < 12; c++) begin
         @(negedge clk);
         n_checks++;
         if ({if_rvalid[4], d_rvalid[4]} !== {1'b0, (c == 8)}) begin
            n_errors++;
            $display("FAIL rmid_rvalid c%0d: got %b want %b", c, {if_rvalid[4], d_rvalid[4]}, {1'b0, (c == 8)});
         end
         next_cycle();
      end
   endtask

   task automatic test_latency_sweep();
      logic [31:0] a;
      for (int l = 1; l <= int'(NL); l++) begin
         a         = $urandom;
         d_req[l]  = 1'b1;
         d_we[l]   = 1'b0;
         d_be[l]   = 4'hF;
         d_addr[l] = a;
         @(negedge clk);
         n_checks++;
         if ({d_gnt[l], mem_addr[l]} !== {1'b1, a}) begin
            n_errors++;
            $display("FAIL sweep_grant L%0d: got %h want %h", l, {d_gnt[l], mem_addr[l]}, {1'b1, a});
         end
         next_cycle();
         d_req[l] = 1'b0;
         for (int c = 1; c <= l + 1; c++) begin
            @(negedge clk);
            n_checks++;
            if ({d_rvalid[l], d_rdata[l]} !== {(c == l), (c == l) ? memf(a) : 32'h0}) begin
               n_errors++;
               $display("FAIL sweep_rvalid L%0d c%0d: got %h want %h", l, c,
                        {d_rvalid[l], d_rdata[l]}, {(c == l), (c == l) ? memf(a) : 32'h0});
            end
            next_cycle();
         end
      end
      clear_inputs();
   endtask

   // Random traffic against a timestamp model: a grant is legal once the port is free,
   // its response lands exactly L cycles later, and ties alternate.
   task automatic test_random();
      int          lats [3] = '{1, 3, 7};
      int          l, free_at, rv_cyc;
      bit          ifp, dp, dwe, last_d, win_d, rv_d, granted;
      logic [3:0]  dbe;
      logic [31:0] ia, da, dwd, rv_data, exp_d, exp_i;
      logic [1:0]  exp_rv;
      for (int k = 0; k < 3; k++) begin
         l = lats[k];
         do_reset();
         free_at = 0;
         rv_cyc  = -1;
         last_d  = 1'b0;
         ifp     = 1'b0;
         dp      = 1'b0;
         rv_d    = 1'b0;
         rv_data = '0;
         for (int cyc = 0; cyc < 150; cyc++) begin
            if (!ifp && $urandom_range(0, 2) != 0) begin
               ifp = 1'b1;
               ia  = $urandom;
            end
            if (!dp && $urandom_range(0, 2) != 0) begin
               dp  = 1'b1;
               dwe = 1'($urandom_range(0, 1));
               dbe = 4'($urandom);
               da  = $urandom;
               dwd = $urandom;
            end
            if_req[l]  = ifp;
            if_addr[l] = ifp ? ia : $urandom;
            d_req[l]   = dp;
            d_we[l]    = dp ? dwe : 1'($urandom_range(0, 1));
            d_be[l]    = dp ? dbe : 4'($urandom);
            d_addr[l]  = dp ? da : $urandom;
            d_wdata[l] = dp ? dwd : $urandom;
            granted = (cyc >= free_at) && (ifp || dp);
            win_d   = (ifp && dp) ? !last_d : dp;
            exp_rv  = (cyc == rv_cyc) ? (rv_d ? 2'b10 : 2'b01) : 2'b00;
            exp_d   = exp_rv[1] ? rv_data : 32'h0;
            exp_i   = exp_rv[0] ? rv_data : 32'h0;
            @(negedge clk);
            n_checks++;
            if ({d_gnt[l], if_gnt[l]} !== {granted && win_d, granted && !win_d}) begin
               n_errors++;
               $display("FAIL rnd_gnt L%0d cyc%0d: got %b want %b", l, cyc,
                        {d_gnt[l], if_gnt[l]}, {granted && win_d, granted && !win_d});
            end
            if (granted && win_d) begin
               n_checks++;
               if ({mem_req[l], mem_we[l], mem_be[l], mem_addr[l], mem_wdata[l]} !== {1'b1, dwe, dbe, da, dwd}) begin
                  n_errors++;
                  $display("FAIL rnd_dmem L%0d cyc%0d: got %h want %h", l, cyc,
                           {mem_req[l], mem_we[l], mem_be[l], mem_addr[l], mem_wdata[l]}, {1'b1, dwe, dbe, da, dwd});
               end
            end else if (granted) begin
               n_checks++;
               if ({mem_req[l], mem_we[l], mem_be[l], mem_addr[l]} !== {1'b1, 1'b0, 4'hF, ia}) begin
                  n_errors++;
                  $display("FAIL rnd_imem L%0d cyc%0d: got %h want %h", l, cyc,
                           {mem_req[l], mem_we[l], mem_be[l], mem_addr[l]}, {1'b1, 1'b0, 4'hF, ia});
               end
            end else begin
               n_checks++;
               if ({mem_req[l], mem_addr[l], mem_wdata[l]} !== '0) begin
                  n_errors++;
                  $display("FAIL rnd_idle L%0d cyc%0d: got %h want 0", l, cyc,
                           {mem_req[l], mem_addr[l], mem_wdata[l]});
               end
            end
            n_checks++;
            if ({d_rvalid[l], if_rvalid[l], d_rdata[l], if_rdata[l]} !== {exp_rv, exp_d, exp_i}) begin
               n_errors++;
               $display("FAIL rnd_resp L%0d cyc%0d: got %h want %h", l, cyc,
                        {d_rvalid[l], if_rvalid[l], d_rdata[l], if_rdata[l]}, {exp_rv, exp_d, exp_i});
            end
            if (granted) begin
               rv_cyc  = cyc + l;
               rv_d    = win_d;
               rv_data = win_d ? (dwe ? 32'h0 : memf(da)) : memf(ia);
               free_at = cyc + l + 1;
               last_d  = win_d;
               if (win_d) dp = 1'b0;
               else       ifp = 1'b0;
            end
            next_cycle();
         end
         clear_inputs();
         for (int c = 0; c < l + 2; c++) next_cycle();
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset_n  = 1'b0;
      clear_inputs();
      @(posedge clk);
      #1;
      test_reset();
      test_single_fetch();
      test_data_write();
      test_tie();
      test_back_to_back();
      test_reset_mid();
      test_latency_sweep();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port memory between the core's instruction-fetch path and its load/store path. Each requester issues a request; the block grants one at a time with two-way round-robin, drives the memory port, and times the fixed memory latency. It returns a one-cycle response (read data or write acknowledge) to the owning requester. It sits between the control unit's fetch/data interfaces and a unified memory.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; must be 32.
- `MEM_LATENCY`, default 1: cycles from a `mem_req` cycle to valid `mem_rdata`; legal range 1..7.

- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request.
- `if_addr`  in  ADDR_W  fetch address.
- `if_gnt`  out  1  fetch request accepted this cycle.
- `if_rvalid`  out  1  fetch data valid, one-cycle pulse.
- `if_rdata`  out  DATA_W  fetch data.
- `d_req`  in  1  data request.
- `d_we`  in  1  1 = write, 0 = read.
- `d_be`  in  4  byte enables for writes.
- `d_addr`  in  ADDR_W  data address.
- `d_wdata`  in  DATA_W  write data.
- `d_gnt`  out  1  data request accepted this cycle.
- `d_rvalid`  out  1  read data or write acknowledge, one-cycle pulse.
- `d_rdata`  out  DATA_W  read data; 0 on write acknowledge.
- `mem_req`, `mem_we`  out  1  memory strobe and write enable.
- `mem_be`  out  4  memory byte enables.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data.

## Operation
- FSM has two states.
  - S_IDLE: no transaction in flight.
  - S_WAIT: one transaction outstanding.
- Only one transaction is outstanding at a time; there is no pipelining.
- In S_IDLE with at least one request:
  - Select the winner.
  - Assert its `*_gnt` combinationally in the same cycle.
  - Drive `mem_req=1` and the winner's address, we, be and wdata combinationally.
  - Go to S_WAIT, set `cnt=1`, and latch `owner` and `is_write`.
  - For a fetch winner: `mem_we=0` and `mem_be=4'hF`.
- Arbitration:
  - If only one requester is active, it wins.
  - On a tie, the requester that was *not* granted last wins.
  - `last_owner` resets to IF, so data wins the first tie.
- In S_WAIT:
  - When `cnt==MEM_LATENCY`, pulse the owner's `*_rvalid` and pass `mem_rdata` through to its `*_rdata`. For a write, pass 0 instead. Go to S_IDLE.
  - Otherwise increment `cnt`.
- No grant is issued in S_WAIT, including the rvalid cycle.
- Requester rules:
  - Hold req and payload stable until gnt.
  - req may stay high after gnt to request again.
- Memory outputs are 0 when `mem_req=0`. Non-owner rdata is 0.
- Reset (`reset_n` low, at any time):
  - State goes to S_IDLE, `cnt` to 0, `last_owner` to IF.
  - All outputs are forced to 0 while reset is low.
  - An in-flight transaction is dropped with no rvalid.

## Timing
- Grant happens in cycle T, the req cycle in S_IDLE (0 wait).
- rvalid happens in cycle T+MEM_LATENCY.
- The next grant is possible at T+MEM_LATENCY+1.
- Peak throughput is one access per MEM_LATENCY+1 cycles.
- `cnt` is 3 bits and never wraps, because MEM_LATENCY ≤ 7.
- A request arriving in the rvalid cycle is granted the following cycle.
- Simultaneous reqs in S_IDLE produce exactly one gnt; the loser waits at least MEM_LATENCY+1 cycles.
- With both reqs held continuously, grants alternate strictly: D, IF, D, IF…
- Reset deassertion takes effect on the first rising edge with `reset_n` high; a grant is possible in that same cycle.

## Structure
- Package `mem_arb_pkg`:
  - `typedef enum logic {S_IDLE, S_WAIT} arb_state_e`
  - `typedef enum logic {OWN_IF, OWN_D} arb_owner_e`
  - `localparam BE_ALL = 4'hF`
- Sub-module `arb_rr2`: combinational two-way round-robin picker (inputs `req[1:0]` and `last_owner`; outputs winner and valid).
- Sequential state (FSM, `cnt`, owner, `is_write`, `last_owner`) stays in `mem_port_arbiter`.

## Test plan
- Single fetch, MEM_LATENCY=1:
  - Stimulus: `if_req=1` with `if_addr=32'h00010000`; memory model returns `32'h00500093`.
  - Required: `if_gnt` and `mem_req` in cycle 0, `mem_addr=32'h00010000`, `mem_we=0`; `if_rvalid=1` in cycle 1 with `if_rdata=32'h00500093`.
- Data write, MEM_LATENCY=3:
  - Stimulus: `d_req=1`, `d_we=1`, `d_be=4'b0011`, `d_addr=32'h100`, `d_wdata=32'hDEADBEEF`.
  - Required: `mem_be=4'b0011` and `mem_wdata=32'hDEADBEEF` in cycle 0; `d_rvalid=1` with `d_rdata=0` in cycle 3 only.
- Tie after reset:
  - Stimulus: both reqs high continuously for 8 cycles at MEM_LATENCY=1.
  - Required: grants at cycles 0, 2, 4, 6, in order D, IF, D, IF; no gnt at odd cycles.
- Back-to-back:
  - Stimulus: `if_req` held high for 6 cycles, MEM_LATENCY=2.
  - Required: `if_gnt` at cycles 0 and 3, `if_rvalid` at cycles 2 and 5.
- Reset mid-operation:
  - Stimulus: MEM_LATENCY=4, grant fetch at cycle 0, pull `reset_n` low at cycle 2 and release at cycle 4 with `d_req=1`.
  - Required: no `if_rvalid` at all; all outputs 0 during reset; `d_gnt` in the first cycle after release.
- Latency sweep:
  - Stimulus: a read at each MEM_LATENCY value 1..7.
  - Required: rvalid exactly MEM_LATENCY cycles after gnt, and `rdata` equal to the memory model value.
